// File: rtl/stdout_uart.sv
// Byte capture from the brainfuck core, small FIFO, and 8N1 UART serialiser.
// Back-pressure via cpu_en keeps one slot free for a byte already in flight.
module stdout_uart #(
   parameter int unsigned CLKS_PER_BIT = 104,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] stdout,
   input  logic       stdout_en,
   output logic       cpu_en,
   output logic       tx,
   output logic       busy,
   output logic       overflow
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned BW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ALMOST   = CW'(FIFO_DEPTH - 1);
   localparam logic [BW-1:0] BAUD_TOP = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          en_q;
   logic [7:0]    shreg, shreg_n;
   logic [BW-1:0] baud_cnt, baud_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic          tx_n;
   logic          wr_ev, push, pop;

   // A held stdout_en level (core stalled) must yield exactly one byte.
   assign wr_ev  = stdout_en && !en_q;
   assign push   = wr_ev && (count < FULL);
   assign cpu_en = count < ALMOST;
   assign busy   = (state != IDLE) || (count != '0);

   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      baud_n    = baud_cnt;
      bit_idx_n = bit_idx;
      tx_n      = tx;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (count != '0) begin
               pop     = 1'b1;
               shreg_n = mem[rd_ptr];
               baud_n  = BAUD_TOP;
               tx_n    = 1'b0;
               state_n = START;
            end
         end
         START: begin
            if (baud_cnt == '0) begin
               tx_n      = shreg[0];
               bit_idx_n = '0;
               baud_n    = BAUD_TOP;
               state_n   = DATA;
            end else begin
               baud_n = baud_cnt - 1'b1;
            end
         end
         DATA: begin
            if (baud_cnt == '0) begin
               baud_n = BAUD_TOP;
               if (bit_idx == 3'd7) begin
                  tx_n    = 1'b1;
                  state_n = STOP;
               end else begin
                  shreg_n   = {1'b0, shreg[7:1]};
                  tx_n      = shreg[1];
                  bit_idx_n = bit_idx + 3'd1;
               end
            end else begin
               baud_n = baud_cnt - 1'b1;
            end
         end
         STOP: begin
            if (baud_cnt == '0) begin
               state_n = IDLE;
            end else begin
               baud_n = baud_cnt - 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tx       <= 1'b1;
         en_q     <= 1'b0;
         overflow <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         shreg    <= '0;
         baud_cnt <= '0;
         bit_idx  <= '0;
      end else begin
         state    <= state_n;
         tx       <= tx_n;
         en_q     <= stdout_en;
         shreg    <= shreg_n;
         baud_cnt <= baud_n;
         bit_idx  <= bit_idx_n;
         // Full is judged on the pre-edge count, so a same-edge pop does not save the byte.
         if (wr_ev && (count == FULL)) overflow <= 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !reset) mem[wr_ptr] <= stdout;
   end
endmodule

// File: tb/tb_stdout_uart.sv
// Directed bench for stdout_uart: scoreboard of expected bytes, cycle-exact
// UART line monitor, and checks on cpu_en / overflow / reset behaviour.
module tb_stdout_uart;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] stdout;
   logic       stdout_en;
   logic       cpu_en, tx, busy, overflow;

   int         vectors      = 0;
   int         miscompares  = 0;
   int         cyc          = 0;
   logic [7:0] sb[$];
   int         starts[$];
   int         frames_started = 0;
   int         frames_done    = 0;
   int         end_cyc        = 0;
   int         busy_fall      = 0;
   logic       busy_q         = 1'b0;

   stdout_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .stdout    (stdout),
      .stdout_en (stdout_en),
      .cpu_en    (cpu_en),
      .tx        (tx),
      .busy      (busy),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (busy_q === 1'b1 && busy === 1'b0) busy_fall <= cyc;
      busy_q <= busy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input bit expect_it);
      stdout    = b;
      stdout_en = 1'b1;
      if (expect_it) sb.push_back(b);
      @(negedge clk);
      stdout_en = 1'b0;
   endtask

   task automatic wait_frames(input int n, input int budget, input string tag);
      int t;
      t = 0;
      while (frames_done < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      check(tag, frames_done, n);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy !== 1'b0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check("idle_reached", busy, 0);
      repeat (4) @(negedge clk);
   endtask

   // Line monitor: checks every cycle of each frame against the scoreboard byte.
   initial begin : uart_monitor
      logic [9:0] line;
      logic [7:0] exp_b, got;
      int         bad;
      bit         aborted;
      forever begin
         @(negedge clk);
         if (reset !== 1'b0 || tx !== 1'b0) continue;
         starts.push_back(cyc);
         frames_started++;
         if (sb.size() == 0) begin
            check("unexpected_frame", frames_started, 0);
            exp_b = 8'h00;
         end else begin
            exp_b = sb.pop_front();
         end
         line    = {1'b1, exp_b, 1'b0};
         bad     = 0;
         got     = 8'h00;
         aborted = 1'b0;
         for (int k = 0; k < 10 * CPB; k++) begin
            if (k != 0) @(negedge clk);
            if (reset !== 1'b0) begin
               aborted = 1'b1;
               break;
            end
            if (tx !== line[k / CPB]) bad++;
            if ((k % CPB) == (CPB / 2) && (k / CPB) >= 1 && (k / CPB) <= 8)
               got[(k / CPB) - 1] = tx;
         end
         if (!aborted) begin
            end_cyc = cyc;
            frames_done++;
            check("frame_timing_bad_cycles", bad, 0);
            check("frame_data", got, exp_b);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: observed simulation still running, expected finish");
      $fatal(1);
   end

   initial begin : stim
      int k0, base, rise, maxc;
      reset     = 1'b1;
      stdout    = '0;
      stdout_en = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_cpu_en", cpu_en, 1);
      check("rst_overflow", overflow, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // single byte 0x41
      base = frames_started;
      k0   = cyc;
      send(8'h41, 1'b1);
      wait_frames(base + 1, 100, "single_frames");
      check("single_latency", starts[base] - k0, 2);
      repeat (2) @(negedge clk);
      check("single_busy_fall", busy_fall, end_cyc + 1);
      check("single_idle_tx", tx, 1);

      // held level: one byte only
      wait_idle();
      base      = frames_started;
      maxc      = 0;
      stdout    = 8'h55;
      stdout_en = 1'b1;
      sb.push_back(8'h55);
      repeat (12) begin
         @(negedge clk);
         if (int'(dut.count) > maxc) maxc = int'(dut.count);
      end
      stdout_en = 1'b0;
      wait_frames(base + 1, 100, "held_frames");
      repeat (50) @(negedge clk);
      check("held_one_frame", frames_started - base, 1);
      check("held_max_count", maxc, 1);

      // back-to-back
      wait_idle();
      base = frames_started;
      send(8'h00, 1'b1);
      repeat (3) @(negedge clk);
      send(8'hFF, 1'b1);
      wait_frames(base + 2, 200, "b2b_frames");
      check("b2b_start_spacing", starts[base + 1] - starts[base], 10 * CPB + 1);

      // stall: cpu_en drops at count == DEPTH-1
      wait_idle();
      base = frames_started;
      send(8'hC0, 1'b1);
      repeat (3) @(negedge clk);
      send(8'hC1, 1'b1);
      repeat (3) @(negedge clk);
      send(8'hC2, 1'b1);
      check("stall_cpu_en_count2", cpu_en, 1);
      repeat (3) @(negedge clk);
      send(8'hC3, 1'b1);
      check("stall_cpu_en_count3", cpu_en, 0);
      rise = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (cpu_en === 1'b1) begin
            rise = cyc;
            break;
         end
      end
      wait_frames(base + 4, 400, "stall_frames");
      check("stall_cpu_en_rise", rise, starts[base + 1]);
      check("stall_overflow", overflow, 0);

      // overflow: 6 bytes ignoring cpu_en, sixth is dropped
      wait_idle();
      base = frames_started;
      for (int i = 0; i < 6; i++) begin
         send(8'(8'h10 + i), i < 5);
         if (i == 4) check("ovf_before_drop", overflow, 0);
         if (i < 5) repeat (3) @(negedge clk);
      end
      check("ovf_set", overflow, 1);
      wait_frames(base + 5, 400, "ovf_frames");
      repeat (60) @(negedge clk);
      check("ovf_no_extra_frames", frames_started - base, 5);
      check("ovf_sticky", overflow, 1);

      // reset during DATA bit 3 with two bytes queued
      wait_idle();
      base = frames_started;
      send(8'hA0, 1'b1);
      repeat (3) @(negedge clk);
      send(8'hA1, 1'b1);
      repeat (3) @(negedge clk);
      send(8'hA2, 1'b1);
      for (int t = 0; t < 100 && cyc < starts[base] + 4 * CPB + 1; t++) @(negedge clk);
      check("rmf_pre_count", dut.count, 2);
      check("rmf_pre_tx_bit3", tx, 0);
      check("rmf_pre_overflow", overflow, 1);
      reset = 1'b1;
      @(negedge clk);
      sb.delete();
      check("rmf_tx", tx, 1);
      check("rmf_busy", busy, 0);
      check("rmf_cpu_en", cpu_en, 1);
      check("rmf_overflow", overflow, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (150) @(negedge clk);
      check("rmf_no_more_frames", frames_started - base, 1);
      check("rmf_tx_idle", tx, 1);
      check("rmf_busy_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
